// File: rtl/lsu_ahb.sv
// Load/store stage: accepts one op per valid/ready handshake, issues a single
// AHB-Lite transfer with byte-lane placement, and resolves branch/squash.
module lsu_ahb #(
    parameter int XLEN = 64
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            mem_en,
    input  logic            load,
    input  logic [2:0]      mem_para,
    input  logic [XLEN-1:0] address,
    input  logic [XLEN-1:0] value,
    input  logic [XLEN-1:0] alu_res,
    input  logic [4:0]      rd_i,
    input  logic            write_back,
    input  logic            branch_flag_i,
    input  logic [XLEN-1:0] branch_offset_i,
    input  logic [XLEN-1:0] PC_i,
    output logic [XLEN-1:0] HADDR,
    output logic [1:0]      HTRANS,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [XLEN-1:0] HWDATA,
    input  logic [XLEN-1:0] HRDATA,
    input  logic            HREADY,
    input  logic            HRESP,
    output logic            out_valid,
    output logic [XLEN-1:0] res,
    output logic [4:0]      rd_o,
    output logic            wb_en,
    output logic            take_branch,
    output logic [XLEN-1:0] branch_offset_o,
    output logic [XLEN-1:0] PC_o,
    output logic            misalign,
    output logic            bus_err,
    output logic [1:0]      dbg_state
);
    localparam int OFFW = $clog2(XLEN / 8);

    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, RESP = 2'd3} state_t;
    state_t state_q, state_d;

    logic            squash_q, squash_d;
    logic [XLEN-1:0] op_addr_q, op_addr_d, op_alu_q, op_alu_d, op_wdata_q, op_wdata_d;
    logic [XLEN-1:0] op_boff_q, op_boff_d, op_pc_q, op_pc_d;
    logic            op_load_q, op_load_d, op_wb_q, op_wb_d, op_tb_q, op_tb_d;
    logic [2:0]      op_para_q, op_para_d;
    logic [4:0]      op_rd_q, op_rd_d;
    logic [XLEN-1:0] res_q, res_d, boff_o_q, boff_o_d, pc_o_q, pc_o_d;
    logic [4:0]      rd_o_q, rd_o_d;
    logic            wb_en_q, wb_en_d, take_branch_q, take_branch_d;
    logic            misalign_q, misalign_d, bus_err_q, bus_err_d;

    logic            illegal, low_mis, mis_in, branch_in, bus_in;
    logic [XLEN-1:0] vmask, ld_shift, ld_ext;

    // Handshake: an op transfers on a rising edge where in_valid && in_ready;
    // in_ready is high only in IDLE, out_valid is high only in RESP.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == RESP);
    assign dbg_state = state_q;

    always_comb begin
        illegal = (mem_para == 3'b111) ||
                  ((XLEN == 32) && ((mem_para == 3'b011) || (mem_para == 3'b110)));
        case (mem_para[1:0])
            2'd0:    low_mis = 1'b0;
            2'd1:    low_mis = address[0];
            2'd2:    low_mis = |address[1:0];
            default: low_mis = |address[2:0];
        endcase
        mis_in    = mem_en && !squash_q && (illegal || low_mis);
        bus_in    = mem_en && !squash_q && !mis_in;
        branch_in = branch_flag_i && (alu_res == XLEN'(1)) && !squash_q;
        case (mem_para[1:0])
            2'd0:    vmask = XLEN'(value[7:0]);
            2'd1:    vmask = XLEN'(value[15:0]);
            2'd2:    vmask = XLEN'(value[31:0]);
            default: vmask = value;
        endcase
        ld_shift = HRDATA >> {op_addr_q[OFFW-1:0], 3'b000};
        case (op_para_q)
            3'b000:  ld_ext = XLEN'($signed(ld_shift[7:0]));
            3'b001:  ld_ext = XLEN'($signed(ld_shift[15:0]));
            3'b010:  ld_ext = XLEN'($signed(ld_shift[31:0]));
            3'b100:  ld_ext = XLEN'(ld_shift[7:0]);
            3'b101:  ld_ext = XLEN'(ld_shift[15:0]);
            3'b110:  ld_ext = XLEN'(ld_shift[31:0]);
            default: ld_ext = ld_shift;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        squash_d      = (state_q == RESP) && take_branch_q;
        op_addr_d     = op_addr_q;
        op_alu_d      = op_alu_q;
        op_wdata_d    = op_wdata_q;
        op_boff_d     = op_boff_q;
        op_pc_d       = op_pc_q;
        op_load_d     = op_load_q;
        op_wb_d       = op_wb_q;
        op_tb_d       = op_tb_q;
        op_para_d     = op_para_q;
        op_rd_d       = op_rd_q;
        res_d         = res_q;
        boff_o_d      = boff_o_q;
        pc_o_d        = pc_o_q;
        rd_o_d        = rd_o_q;
        wb_en_d       = wb_en_q;
        take_branch_d = take_branch_q;
        misalign_d    = misalign_q;
        bus_err_d     = bus_err_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_addr_d  = address;
                    op_alu_d   = alu_res;
                    op_wdata_d = vmask << {address[OFFW-1:0], 3'b000};
                    op_boff_d  = branch_offset_i;
                    op_pc_d    = PC_i;
                    op_load_d  = load;
                    op_wb_d    = load && write_back && (rd_i != 5'd0);
                    op_tb_d    = branch_in;
                    op_para_d  = mem_para;
                    op_rd_d    = rd_i;
                    if (bus_in) begin
                        state_d = ADDR;
                    end else begin
                        // Non-memory, misaligned and squashed ops finish without the bus.
                        state_d       = RESP;
                        res_d         = alu_res;
                        rd_o_d        = (squash_q || mis_in) ? 5'd0 : rd_i;
                        wb_en_d       = !squash_q && !mem_en && write_back;
                        take_branch_d = branch_in;
                        misalign_d    = mis_in;
                        bus_err_d     = 1'b0;
                        boff_o_d      = branch_offset_i;
                        pc_o_d        = PC_i;
                    end
                end
            end
            ADDR: state_d = DATA;
            DATA: begin
                if (HREADY) begin
                    state_d       = RESP;
                    res_d         = op_load_q ? ld_ext : op_alu_q;
                    rd_o_d        = op_rd_q;
                    wb_en_d       = op_wb_q && !HRESP;
                    take_branch_d = op_tb_q;
                    misalign_d    = 1'b0;
                    bus_err_d     = HRESP;
                    boff_o_d      = op_boff_q;
                    pc_o_d        = op_pc_q;
                end
            end
            RESP: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= IDLE;
            squash_q      <= 1'b0;
            op_addr_q     <= '0;
            op_alu_q      <= '0;
            op_wdata_q    <= '0;
            op_boff_q     <= '0;
            op_pc_q       <= '0;
            op_load_q     <= 1'b0;
            op_wb_q       <= 1'b0;
            op_tb_q       <= 1'b0;
            op_para_q     <= 3'd0;
            op_rd_q       <= 5'd0;
            res_q         <= '0;
            boff_o_q      <= '0;
            pc_o_q        <= '0;
            rd_o_q        <= 5'd0;
            wb_en_q       <= 1'b0;
            take_branch_q <= 1'b0;
            misalign_q    <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            squash_q      <= squash_d;
            op_addr_q     <= op_addr_d;
            op_alu_q      <= op_alu_d;
            op_wdata_q    <= op_wdata_d;
            op_boff_q     <= op_boff_d;
            op_pc_q       <= op_pc_d;
            op_load_q     <= op_load_d;
            op_wb_q       <= op_wb_d;
            op_tb_q       <= op_tb_d;
            op_para_q     <= op_para_d;
            op_rd_q       <= op_rd_d;
            res_q         <= res_d;
            boff_o_q      <= boff_o_d;
            pc_o_q        <= pc_o_d;
            rd_o_q        <= rd_o_d;
            wb_en_q       <= wb_en_d;
            take_branch_q <= take_branch_d;
            misalign_q    <= misalign_d;
            bus_err_q     <= bus_err_d;
        end
    end

    // Address-phase signals exist only in ADDR; write data only in DATA of a store.
    assign HTRANS          = (state_q == ADDR) ? 2'b10 : 2'b00;
    assign HADDR           = (state_q == ADDR) ? op_addr_q : '0;
    assign HWRITE          = (state_q == ADDR) && !op_load_q;
    assign HSIZE           = (state_q == ADDR) ? {1'b0, op_para_q[1:0]} : 3'd0;
    assign HWDATA          = ((state_q == DATA) && !op_load_q) ? op_wdata_q : '0;
    assign res             = res_q;
    assign rd_o            = rd_o_q;
    assign wb_en           = wb_en_q;
    assign take_branch     = take_branch_q;
    assign misalign        = misalign_q;
    assign bus_err         = bus_err_q;
    assign branch_offset_o = boff_o_q;
    assign PC_o            = pc_o_q;
endmodule

// File: tb/tb_lsu_ahb.sv
// Directed bench for lsu_ahb (XLEN=64): loads, stores, misalign, wait states,
// branch squash, bus error and mid-transfer reset, checked with assertions.
module tb_lsu_ahb;
    logic        CLK, RST_N;
    logic        in_valid, in_ready, mem_en, load, write_back, branch_flag_i;
    logic [2:0]  mem_para;
    logic [63:0] address, value, alu_res, branch_offset_i, PC_i;
    logic [4:0]  rd_i, rd_o;
    logic [63:0] HADDR, HWDATA, HRDATA, res, branch_offset_o, PC_o;
    logic [1:0]  HTRANS, dbg_state;
    logic        HWRITE, HREADY, HRESP;
    logic [2:0]  HSIZE;
    logic        out_valid, wb_en, take_branch, misalign, bus_err;

    int checks = 0;
    int errors = 0;

    lsu_ahb #(.XLEN(64)) dut (
        .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready),
        .mem_en(mem_en), .load(load), .mem_para(mem_para), .address(address),
        .value(value), .alu_res(alu_res), .rd_i(rd_i), .write_back(write_back),
        .branch_flag_i(branch_flag_i), .branch_offset_i(branch_offset_i), .PC_i(PC_i),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .out_valid(out_valid), .res(res), .rd_o(rd_o), .wb_en(wb_en),
        .take_branch(take_branch), .branch_offset_o(branch_offset_o), .PC_o(PC_o),
        .misalign(misalign), .bus_err(bus_err), .dbg_state(dbg_state)
    );

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // driver: presents one op for one accepting edge
    task automatic issue(input logic mem, input logic ld, input logic [2:0] para,
                         input logic [63:0] addr, input logic [63:0] val,
                         input logic [63:0] alu, input logic [4:0] rd,
                         input logic wb, input logic br);
        mem_en = mem; load = ld; mem_para = para; address = addr; value = val;
        alu_res = alu; rd_i = rd; write_back = wb; branch_flag_i = br;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        RST_N = 1'b0; in_valid = 1'b0; mem_en = 1'b0; load = 1'b0; mem_para = 3'd0;
        address = '0; value = '0; alu_res = '0; rd_i = '0; write_back = 1'b0;
        branch_flag_i = 1'b0; branch_offset_i = '0; PC_i = '0;
        HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_htrans", HTRANS, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_res", res, 0);
        chk("rst_state", dbg_state, 0);
        RST_N = 1'b1;
        tick();

        // LW 0x1004: upper word of HRDATA, sign-extended
        HRDATA = 64'h8000_0001_DEAD_BEEF;
        issue(1, 1, 3'b010, 64'h1004, 0, 64'h77, 5'd5, 1, 0);
        chk("lw_htrans", HTRANS, 2'b10);
        chk("lw_haddr", HADDR, 64'h1004);
        chk("lw_hsize", HSIZE, 3'd2);
        chk("lw_hwrite", HWRITE, 0);
        chk("lw_in_ready", in_ready, 0);
        tick();
        chk("lw_data_htrans", HTRANS, 0);
        chk("lw_data_valid", out_valid, 0);
        tick();
        chk("lw_valid", out_valid, 1);
        chk("lw_res", res, 64'hFFFF_FFFF_8000_0001);
        chk("lw_wb_en", wb_en, 1);
        chk("lw_rd", rd_o, 5);
        tick();
        chk("lw_pulse", out_valid, 0);
        chk("lw_ready_again", in_ready, 1);
        chk("lw_res_hold", res, 64'hFFFF_FFFF_8000_0001);

        // SB 0x1003: only the selected byte lane carries data
        issue(1, 0, 3'b000, 64'h1003, 64'h1234_5678_9ABC_DEAB, 0, 5'd7, 1, 0);
        chk("sb_htrans", HTRANS, 2'b10);
        chk("sb_hwrite", HWRITE, 1);
        chk("sb_hsize", HSIZE, 0);
        tick();
        chk("sb_hwdata", HWDATA, 64'h0000_0000_AB00_0000);
        tick();
        chk("sb_valid", out_valid, 1);
        chk("sb_wb_en", wb_en, 0);
        tick();

        // LBU 0x1007 with rd=0: zero-extended top byte, no write-back
        HRDATA = 64'hF011_2233_4455_6677;
        issue(1, 1, 3'b100, 64'h1007, 0, 0, 5'd0, 1, 0);
        tick();
        tick();
        chk("lbu_valid", out_valid, 1);
        chk("lbu_res", res, 64'hF0);
        chk("lbu_wb_rd0", wb_en, 0);
        tick();

        // LH 0x1001: misaligned, no bus transfer
        issue(1, 1, 3'b001, 64'h1001, 0, 0, 5'd6, 1, 0);
        chk("lh_htrans", HTRANS, 0);
        chk("lh_valid", out_valid, 1);
        chk("lh_misalign", misalign, 1);
        chk("lh_wb_en", wb_en, 0);
        chk("lh_rd", rd_o, 0);
        tick();

        // LD with three wait states
        HRDATA = 64'h0123_4567_89AB_CDEF;
        HREADY = 1'b0;
        issue(1, 1, 3'b011, 64'h2000, 0, 0, 5'd8, 1, 0);
        chk("ld_htrans", HTRANS, 2'b10);
        chk("ld_hsize", HSIZE, 3);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ld_wait_ready", in_ready, 0);
            chk("ld_wait_valid", out_valid, 0);
            chk("ld_wait_htrans", HTRANS, 0);
            chk("ld_wait_hwdata", HWDATA, 0);
        end
        tick();
        HREADY = 1'b1;
        chk("ld_last_valid", out_valid, 0);
        tick();
        chk("ld_valid", out_valid, 1);
        chk("ld_res", res, 64'h0123_4567_89AB_CDEF);
        chk("ld_wb_en", wb_en, 1);
        tick();

        // non-memory op
        issue(0, 0, 3'b000, 0, 0, 64'h55, 5'd10, 1, 0);
        chk("alu_valid", out_valid, 1);
        chk("alu_res", res, 64'h55);
        chk("alu_wb_en", wb_en, 1);
        chk("alu_rd", rd_o, 10);
        chk("alu_tb", take_branch, 0);
        tick();

        // taken branch, then SW squashed
        PC_i = 64'h400; branch_offset_i = 64'h40;
        issue(0, 0, 3'b000, 0, 0, 64'h1, 5'd0, 0, 1);
        chk("br_valid", out_valid, 1);
        chk("br_taken", take_branch, 1);
        chk("br_pc", PC_o, 64'h400);
        chk("br_off", branch_offset_o, 64'h40);
        tick();
        issue(1, 0, 3'b010, 64'h3000, 64'h1122_3344, 0, 5'd3, 0, 0);
        chk("sq_htrans", HTRANS, 0);
        chk("sq_valid", out_valid, 1);
        chk("sq_wb_en", wb_en, 0);
        chk("sq_rd", rd_o, 0);
        chk("sq_tb", take_branch, 0);
        tick();

        // not-taken branch, then SW performed
        issue(0, 0, 3'b000, 0, 0, 64'h0, 5'd0, 0, 1);
        chk("nbr_taken", take_branch, 0);
        tick();
        issue(1, 0, 3'b010, 64'h3004, 64'h1122_3344, 0, 5'd3, 0, 0);
        chk("sw_htrans", HTRANS, 2'b10);
        chk("sw_hwrite", HWRITE, 1);
        tick();
        chk("sw_hwdata", HWDATA, 64'h1122_3344_0000_0000);
        tick();
        chk("sw_valid", out_valid, 1);
        chk("sw_wb_en", wb_en, 0);
        tick();

        // bus error on a load
        HRESP = 1'b1;
        issue(1, 1, 3'b010, 64'h1008, 0, 0, 5'd9, 1, 0);
        tick();
        tick();
        chk("err_valid", out_valid, 1);
        chk("err_bus_err", bus_err, 1);
        chk("err_wb_en", wb_en, 0);
        HRESP = 1'b0;
        tick();

        // reset while in DATA abandons the op
        HREADY = 1'b0;
        issue(1, 1, 3'b010, 64'h1000, 0, 0, 5'd4, 1, 0);
        tick();
        chk("rstd_state_data", dbg_state, 2);
        #2 RST_N = 1'b0;
        #1;
        chk("rstd_htrans", HTRANS, 0);
        chk("rstd_state", dbg_state, 0);
        chk("rstd_valid", out_valid, 0);
        chk("rstd_res", res, 0);
        #1 RST_N = 1'b1;
        HREADY = 1'b1;
        tick();
        chk("rstd_no_valid1", out_valid, 0);
        tick();
        chk("rstd_no_valid2", out_valid, 0);
        chk("rstd_ready", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_ahb.md
# lsu_ahb

Parametrised load/store stage for the RV pipeline. It sits between execute and write-back and issues single AHB-Lite transfers with correct byte-lane placement. It supports wait states via HREADY and detects misaligned accesses. It resolves the taken-branch decision and squashes the instruction that follows a taken branch. Upstream sees a valid/ready handshake, so the stage can stall execute while the bus is busy.

## Interface
- XLEN, 64, datapath and address width; legal values 32 or 64.
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- in_valid  in  1  execute presents an op.
- in_ready  out  1  stage can accept; high only in IDLE.
- mem_en  in  1  op is a load or store.
- load  in  1  1 = load, 0 = store; ignored when mem_en=0.
- mem_para  in  3  funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- address  in  XLEN  effective address.
- value  in  XLEN  store data (LSBs).
- alu_res  in  XLEN  ALU result; also the branch condition.
- rd_i  in  5  destination register.
- write_back  in  1  op writes rd.
- branch_flag_i  in  1  op is a conditional branch.
- branch_offset_i, PC_i  in  XLEN  forwarded unchanged.
- HADDR  out  XLEN  bus address.
- HTRANS  out  2  00 IDLE, 10 NONSEQ.
- HWRITE  out  1  bus write.
- HSIZE  out  3  log2(bytes).
- HWDATA  out  XLEN  lane-placed store data.
- HRDATA  in  XLEN  read data.
- HREADY  in  1  data phase complete.
- HRESP  in  1  1 = error.
- out_valid  out  1  one-cycle pulse; result and flags valid.
- res  out  XLEN  load data (extended) or alu_res.
- rd_o  out  5  destination; 0 when squashed.
- wb_en  out  1  write-back enable.
- take_branch  out  1  branch taken; valid with out_valid.
- branch_offset_o, PC_o  out  XLEN  forwarded values.
- misalign  out  1  misaligned access; valid with out_valid.
- bus_err  out  1  HRESP error; valid with out_valid.

## Operation
- States: IDLE, ADDR, DATA, RESP.
- Handshake: transfer occurs when in_valid && in_ready. All inputs are registered on acceptance.
- Non-memory op: IDLE→RESP. res=alu_res, wb_en=write_back.
- Size: sz = mem_para[1:0]. The op is misaligned when the address[sz-1:0] bits are not zero.
- When XLEN=32, mem_para 011 and 110 are illegal. Illegal encodings are treated as misaligned.
- Misaligned op: no bus transfer, IDLE→RESP. misalign=1, wb_en=0, rd_o=0.
- Aligned memory op: IDLE→ADDR→DATA→RESP.
  - ADDR drives HTRANS=10, HADDR=address, HWRITE=!load, HSIZE=sz.
  - DATA drives HTRANS=00 and holds HWDATA until HREADY=1.
- Lane offset: off = address[log2(XLEN/8)-1:0].
  - Store: HWDATA = value << (8·off), with unused lanes 0. There is no read-modify-write.
  - Load: d = HRDATA >> (8·off). Sign-extend or zero-extend d[8·2^sz-1:0] to XLEN per mem_para[2].
- Store: wb_en=0. Load: wb_en=write_back, except when rd_i=0, where wb_en=0.
- HRESP=1 together with HREADY=1 gives bus_err=1, wb_en=0.
- Branch: take_branch=1 on an accepted op iff branch_flag_i && alu_res==1.
- Squash: the op accepted in the cycle after an out_valid carrying take_branch=1 is squashed.
  - A squashed op issues no bus transfer, goes IDLE→RESP, and gives wb_en=0, rd_o=0, take_branch=0.

## Timing
- Reset (async): state=IDLE; HTRANS=00, HWRITE=0, HSIZE=0, HADDR=0, HWDATA=0.
  - Also cleared: out_valid, wb_en, take_branch, misalign, bus_err, res, rd_o, branch_offset_o, PC_o, squash flag.
  - Reset mid-transfer abandons the op with no out_valid.
- Non-memory, misaligned and squashed ops: out_valid in cycle N+1 after acceptance at edge N. Throughput is one op every 2 cycles.
- Memory op, zero wait: accepted at edge N, ADDR in cycle N+1, DATA in cycle N+2, out_valid in cycle N+3.
- Each HREADY=0 cycle in DATA adds one cycle.
- in_ready is low from ADDR through RESP and high again the cycle after out_valid.
- out_valid lasts exactly one cycle; all output fields hold until the next out_valid.
- HTRANS is 10 for exactly one cycle per transfer.

## Test plan
- XLEN=64, LW address 0x1004, HRDATA=0x8000_0001_xxxx_xxxx, HREADY=1 -> HSIZE=2, res=0xFFFF_FFFF_8000_0001, wb_en=1, out_valid 3 cycles after accept.
- SB address 0x1003, value 0xAB -> HWDATA=0x0000_0000_AB00_0000, HWRITE=1, wb_en=0.
- LH address 0x1001 -> no HTRANS=10 cycle, misalign=1, wb_en=0, rd_o=0.
- LD with HREADY low for 3 cycles -> out_valid at accept+6, in_ready low throughout, HWDATA stable.
- Branch with branch_flag_i=1, alu_res=1, followed by SW -> take_branch=1; SW squashed with no bus transfer, wb_en=0. Same with alu_res=0 -> SW performed normally.
- RST_N low while in DATA -> HTRANS=00 and state IDLE immediately, no out_valid. HRESP=1 on a load -> bus_err=1, wb_en=0.
